// File: rtl/addsub_acc_if.sv
// rtl/addsub_acc_if.sv - operand/result bundle for the registered add/sub accumulator
interface addsub_acc_if #(
   parameter int WIDTH = 9
);
   logic             CLR;
   logic             IN_VLD;
   logic             ACC;
   logic             ADD;
   logic             CI;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OUT_VLD;
   logic [WIDTH-1:0] S;
   logic             CO;
   logic             OFL;
   logic             SAT_HIT;
   logic             OFL_STKY;

   modport master (
      output CLR, IN_VLD, ACC, ADD, CI, A, B,
      input  OUT_VLD, S, CO, OFL, SAT_HIT, OFL_STKY
   );

   modport slave (
      input  CLR, IN_VLD, ACC, ADD, CI, A, B,
      output OUT_VLD, S, CO, OFL, SAT_HIT, OFL_STKY
   );
endinterface

// File: rtl/addsub_acc.sv
// rtl/addsub_acc.sv - registered add/sub with accumulate, optional clamping and sticky overflow
module addsub_acc #(
   parameter int WIDTH  = 9,
   parameter bit SIGNED = 1'b1,
   parameter bit SAT    = 1'b1
) (
   input  logic         CLK,
   input  logic         RST_N,
   addsub_acc_if.slave  bus
);
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ofl_q, ofl_d;
   logic             hit_q, hit_d;
   logic             stky_q, stky_d;
   logic             vld_q, vld_d;

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   raw;
   logic             ofl;
   logic             oor;
   logic [WIDTH-1:0] clamp;

   // The left operand comes straight from the result register, so accumulation runs back-to-back.
   always_comb begin
      x     = bus.ACC ? s_q : bus.A;
      b_eff = bus.ADD ? bus.B : ~bus.B;
      raw   = {1'b0, x} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.CI};
      ofl   = (x[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
      if (SIGNED) begin
         oor   = ofl;
         clamp = x[WIDTH-1] ? SMIN : SMAX;
      end else begin
         oor   = bus.ADD ? raw[WIDTH] : ~raw[WIDTH];
         clamp = bus.ADD ? UMAX : '0;
      end
   end

   always_comb begin
      s_d    = s_q;
      co_d   = co_q;
      ofl_d  = ofl_q;
      hit_d  = hit_q;
      stky_d = stky_q;
      vld_d  = 1'b0;
      if (bus.CLR) begin
         s_d    = '0;
         co_d   = 1'b0;
         ofl_d  = 1'b0;
         hit_d  = 1'b0;
         stky_d = 1'b0;
      end else if (bus.IN_VLD) begin
         vld_d  = 1'b1;
         co_d   = raw[WIDTH];
         ofl_d  = ofl;
         stky_d = stky_q | oor;
         if (SAT && oor) begin
            s_d   = clamp;
            hit_d = 1'b1;
         end else begin
            s_d   = raw[WIDTH-1:0];
            hit_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         s_q    <= '0;
         co_q   <= 1'b0;
         ofl_q  <= 1'b0;
         hit_q  <= 1'b0;
         stky_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         co_q   <= co_d;
         ofl_q  <= ofl_d;
         hit_q  <= hit_d;
         stky_q <= stky_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.S        = s_q;
   assign bus.CO       = co_q;
   assign bus.OFL      = ofl_q;
   assign bus.SAT_HIT  = hit_q;
   assign bus.OFL_STKY = stky_q;
   assign bus.OUT_VLD  = vld_q;
endmodule

// File: tb/tb_addsub_acc.sv
// tb/tb_addsub_acc.sv - vector table plus randomized model check of three addsub_acc configurations
module tb_addsub_acc;
   localparam int W = 9;
   localparam int M = 512;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   addsub_acc_if #(.WIDTH(W)) if_ss ();
   addsub_acc_if #(.WIDTH(W)) if_sw ();
   addsub_acc_if #(.WIDTH(W)) if_us ();

   addsub_acc #(.WIDTH(W), .SIGNED(1'b1), .SAT(1'b1)) u_ss (.CLK(CLK), .RST_N(RST_N), .bus(if_ss.slave));
   addsub_acc #(.WIDTH(W), .SIGNED(1'b1), .SAT(1'b0)) u_sw (.CLK(CLK), .RST_N(RST_N), .bus(if_sw.slave));
   addsub_acc #(.WIDTH(W), .SIGNED(1'b0), .SAT(1'b1)) u_us (.CLK(CLK), .RST_N(RST_N), .bus(if_us.slave));

   typedef struct {
      bit rst_n, clr, vld, acc, add, ci;
      int a, b;
      int s; bit co, ofl, hit, stky, ovld;
      int s_sw, s_us; bit hit_us;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int failures = 0;

   // reference state per configuration: 0 signed+sat, 1 signed+wrap, 2 unsigned+sat
   int m_s[3];
   bit m_co[3], m_ofl[3], m_hit[3], m_stky[3], m_vld[3];
   bit cfg_sgn[3] = '{1'b1, 1'b1, 1'b0};
   bit cfg_sat[3] = '{1'b1, 1'b0, 1'b1};

   function automatic vec_t mk(bit rst_n, bit clr, bit vld, bit acc, bit add, bit ci, int a, int b,
                               int s, bit co, bit ofl, bit hit, bit stky, bit ovld,
                               int s_sw, int s_us, bit hit_us);
      vec_t v;
      v.rst_n = rst_n; v.clr = clr; v.vld = vld; v.acc = acc; v.add = add; v.ci = ci;
      v.a = a; v.b = b; v.s = s; v.co = co; v.ofl = ofl; v.hit = hit; v.stky = stky; v.ovld = ovld;
      v.s_sw = s_sw; v.s_us = s_us; v.hit_us = hit_us;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit rst_n, bit clr, bit vld, bit acc, bit add, bit ci, int a, int b);
      RST_N = rst_n;
      if_ss.CLR = clr; if_ss.IN_VLD = vld; if_ss.ACC = acc; if_ss.ADD = add; if_ss.CI = ci;
      if_ss.A = W'(a); if_ss.B = W'(b);
      if_sw.CLR = clr; if_sw.IN_VLD = vld; if_sw.ACC = acc; if_sw.ADD = add; if_sw.CI = ci;
      if_sw.A = W'(a); if_sw.B = W'(b);
      if_us.CLR = clr; if_us.IN_VLD = vld; if_us.ACC = acc; if_us.ADD = add; if_us.CI = ci;
      if_us.A = W'(a); if_us.B = W'(b);
   endtask

   // Arithmetic on true integer values; range tests decide overflow and clamping.
   function automatic void model_op(bit sgn, bit sat, int x, int b, bit add, bit ci,
                                    output int s, output bit co, output bit ofl,
                                    output bit hit, output bit oor);
      int uraw, xs, bs, strue, utrue;
      uraw  = x + (add ? b : (M - 1 - b)) + int'(ci);
      co    = (uraw >= M);
      xs    = (x >= M/2) ? x - M : x;
      bs    = (b >= M/2) ? b - M : b;
      strue = add ? xs + bs + int'(ci) : xs - bs - 1 + int'(ci);
      utrue = add ? x + b + int'(ci) : x - b - 1 + int'(ci);
      ofl   = (strue > M/2 - 1) || (strue < -M/2);
      oor   = sgn ? ofl : ((utrue > M - 1) || (utrue < 0));
      hit   = sat && oor;
      if (hit) s = sgn ? ((strue < 0) ? M/2 : M/2 - 1) : ((utrue < 0) ? 0 : M - 1);
      else     s = uraw % M;
   endfunction

   task automatic model_step(bit rst_n, bit clr, bit vld, bit acc, bit add, bit ci, int a, int b);
      int s; bit co, ofl, hit, oor;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n || clr) begin
            m_s[k] = 0; m_co[k] = 0; m_ofl[k] = 0; m_hit[k] = 0; m_stky[k] = 0; m_vld[k] = 0;
         end else if (vld) begin
            model_op(cfg_sgn[k], cfg_sat[k], acc ? m_s[k] : a, b, add, ci, s, co, ofl, hit, oor);
            m_s[k] = s; m_co[k] = co; m_ofl[k] = ofl; m_hit[k] = hit;
            m_stky[k] = m_stky[k] | oor; m_vld[k] = 1;
         end else begin
            m_vld[k] = 0;
         end
      end
   endtask

   task automatic compare_model(int k);
      int s; bit co, ofl, hit, stky, vld;
      case (k)
         0: begin s = int'(if_ss.S); co = if_ss.CO; ofl = if_ss.OFL; hit = if_ss.SAT_HIT; stky = if_ss.OFL_STKY; vld = if_ss.OUT_VLD; end
         1: begin s = int'(if_sw.S); co = if_sw.CO; ofl = if_sw.OFL; hit = if_sw.SAT_HIT; stky = if_sw.OFL_STKY; vld = if_sw.OUT_VLD; end
         default: begin s = int'(if_us.S); co = if_us.CO; ofl = if_us.OFL; hit = if_us.SAT_HIT; stky = if_us.OFL_STKY; vld = if_us.OUT_VLD; end
      endcase
      check($sformatf("rand_s[%0d]", k), s, m_s[k]);
      check($sformatf("rand_co[%0d]", k), int'(co), int'(m_co[k]));
      check($sformatf("rand_ofl[%0d]", k), int'(ofl), int'(m_ofl[k]));
      check($sformatf("rand_hit[%0d]", k), int'(hit), int'(m_hit[k]));
      check($sformatf("rand_stky[%0d]", k), int'(stky), int'(m_stky[k]));
      check($sformatf("rand_vld[%0d]", k), int'(vld), int'(m_vld[k]));
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (2) @(posedge CLK);
      #1;
      check("rst_s", int'(if_ss.S), 0);
      check("rst_co", int'(if_ss.CO), 0);
      check("rst_ofl", int'(if_ss.OFL), 0);
      check("rst_hit", int'(if_ss.SAT_HIT), 0);
      check("rst_stky", int'(if_ss.OFL_STKY), 0);
      check("rst_vld", int'(if_ss.OUT_VLD), 0);

      tbl.push_back(mk(1,1,0,0,0,0,   0,  0,  'h000,0,0,0,0,0, 'h000,'h000,0));
      tbl.push_back(mk(1,0,1,0,0,1,  23, 80,  'h1C7,0,0,0,0,1, 'h1C7,'h000,1));
      tbl.push_back(mk(1,0,0,0,0,0,   0,  0,  'h1C7,0,0,0,0,0, 'h1C7,'h000,1));
      tbl.push_back(mk(1,0,1,0,1,0, 200,100,  'h0FF,0,1,1,1,1, 'h12C,'h12C,0));
      tbl.push_back(mk(1,0,1,0,1,0,   1,  1,  'h002,0,0,0,1,1, 'h002,'h002,0));
      tbl.push_back(mk(1,1,0,0,0,0,   0,  0,  'h000,0,0,0,0,0, 'h000,'h000,0));
      tbl.push_back(mk(1,0,1,0,0,1,'h138,100, 'h100,1,1,1,1,1, 'h0D4,'h0D4,0));
      tbl.push_back(mk(1,1,0,0,0,0,   0,  0,  'h000,0,0,0,0,0, 'h000,'h000,0));
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(1,0,1,1,1,0, 0, 10, 10*k,0,0,0,0,1, 10*k,10*k,0));
      tbl.push_back(mk(1,1,1,1,1,0,   0, 10,  'h000,0,0,0,0,0, 'h000,'h000,0));
      tbl.push_back(mk(1,0,1,1,1,0,   0, 10,  10,0,0,0,0,1,    10,10,0));
      tbl.push_back(mk(0,0,1,1,1,0,   0, 10,  'h000,0,0,0,0,0, 'h000,'h000,0));
      tbl.push_back(mk(1,0,1,1,1,0,   0, 10,  10,0,0,0,0,1,    10,10,0));
      tbl.push_back(mk(1,0,1,0,1,0, 500, 20,  'h008,1,0,0,0,1, 'h008,'h1FF,1));
      tbl.push_back(mk(1,0,1,0,0,1,   5,  9,  'h1FC,0,0,0,0,1, 'h1FC,'h000,1));

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].clr, tbl[i].vld, tbl[i].acc, tbl[i].add, tbl[i].ci, tbl[i].a, tbl[i].b);
         @(posedge CLK);
         #1;
         check($sformatf("v%0d_s", i), int'(if_ss.S), tbl[i].s);
         check($sformatf("v%0d_co", i), int'(if_ss.CO), int'(tbl[i].co));
         check($sformatf("v%0d_ofl", i), int'(if_ss.OFL), int'(tbl[i].ofl));
         check($sformatf("v%0d_hit", i), int'(if_ss.SAT_HIT), int'(tbl[i].hit));
         check($sformatf("v%0d_stky", i), int'(if_ss.OFL_STKY), int'(tbl[i].stky));
         check($sformatf("v%0d_vld", i), int'(if_ss.OUT_VLD), int'(tbl[i].ovld));
         check($sformatf("v%0d_s_wrap", i), int'(if_sw.S), tbl[i].s_sw);
         check($sformatf("v%0d_s_uns", i), int'(if_us.S), tbl[i].s_us);
         check($sformatf("v%0d_hit_uns", i), int'(if_us.SAT_HIT), int'(tbl[i].hit_us));
      end

      // sticky survives a clean op, then only CLR drops it
      drive(1,0,1,0,1,0, 200, 100); @(posedge CLK); #1;
      drive(1,0,1,0,1,0, 1, 1);     @(posedge CLK); #1;
      check("stky_hold", int'(if_ss.OFL_STKY), 1);
      drive(1,0,0,0,0,0, 0, 0);     @(posedge CLK); #1;
      check("stky_idle", int'(if_ss.OFL_STKY), 1);
      drive(1,1,0,0,0,0, 0, 0);     @(posedge CLK); #1;
      check("stky_clr", int'(if_ss.OFL_STKY), 0);

      for (int k = 0; k < 3; k++) begin
         m_s[k] = 0; m_co[k] = 0; m_ofl[k] = 0; m_hit[k] = 0; m_stky[k] = 0; m_vld[k] = 0;
      end
      for (int n = 0; n < 400; n++) begin
         bit rst_n, clr, vld, acc, add, ci;
         int a, b;
         rst_n = ($urandom_range(0, 39) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         vld   = ($urandom_range(0, 3) != 0);
         acc   = $urandom_range(0, 1);
         add   = $urandom_range(0, 1);
         ci    = $urandom_range(0, 1);
         a     = $urandom_range(0, M - 1);
         b     = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 0 : M - 1) : $urandom_range(0, M - 1);
         drive(rst_n, clr, vld, acc, add, ci, a, b);
         model_step(rst_n, clr, vld, acc, add, ci, a, b);
         @(posedge CLK);
         #1;
         for (int k = 0; k < 3; k++) compare_model(k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
